ex_mem_stage: RTL
=================

# ex_mem_stage

EX/MEM pipeline register with a multi-cycle stall sequencer. It sits directly downstream of the execute-stage ALU. It captures the ALU result, store data and control bits for the memory stage. It holds the front of the pipeline while a MUL/DIV operation runs in the ALU's iterative multiplier/divider, and it keeps a finished MUL/DIV result buffered while the memory stage is stalled.

## Interface
Parameters:
- XLEN, 32, datapath width
- REG_ADDR_BITS, 5, register index width

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  EX stage holds a live instruction
- in_md_op  in  1  instruction is MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU (decoded upstream)
- in_is_branch  in  1  instruction is a conditional branch or JAL/JALR
- alu_result  in  XLEN  ALU result
- alu_is_zero  in  1  ALU branch-taken flag
- alu_ready  in  1  one-cycle pulse from the ALU multiplier/divider, marks a valid result
- in_wdata  in  XLEN  store data (rs2 value)
- in_target  in  XLEN  branch/jump target address
- in_rd  in  REG_ADDR_BITS  destination register
- in_reg_write, in_mem_read, in_mem_write  in  1 each  control bits
- mem_stall  in  1  memory stage cannot accept, EX/MEM must hold
- stall_up  out  1  hold IF/ID/EX registers and PC
- md_squash  out  1  upstream forces ALU ctrl to a non-MUL/DIV code (prevents multDiv restart)
- out_valid  out  1  EX/MEM holds a live instruction
- out_result, out_wdata, out_target  out  XLEN  registered copies
- out_rd  out  REG_ADDR_BITS; out_reg_write, out_mem_read, out_mem_write, out_branch_taken  out  1 each

## Operation
- FSM states: IDLE, MD_WAIT, MD_HOLD. Reset state: IDLE.
- ex_done = in_valid & (!in_md_op | (state==MD_WAIT & alu_ready) | state==MD_HOLD).
- load = !mem_stall. On load, EX/MEM takes new contents:
  - If ex_done: out_valid=1 and all fields update.
  - Otherwise: out_valid=0 and out_reg_write, out_mem_read, out_mem_write and out_branch_taken are forced to 0 (bubble).
- mem_stall=1 holds every output register unchanged.
- Result source: md_buf in MD_HOLD, otherwise alu_result.
- out_branch_taken = in_is_branch & alu_is_zero, registered.
- stall_up = in_valid & !(ex_done & !mem_stall).
- md_squash = (state==MD_HOLD). The full instruction stays held upstream; only the ALU ctrl is masked.
- Transitions:
  - IDLE → MD_WAIT when in_valid & in_md_op. EX/MEM loads a bubble that cycle if !mem_stall.
  - MD_WAIT, alu_ready & !mem_stall → IDLE, result loaded directly.
  - MD_WAIT, alu_ready & mem_stall → MD_HOLD, alu_result captured into md_buf.
  - MD_WAIT, !alu_ready → stay.
  - MD_HOLD & !mem_stall → IDLE, md_buf loaded.
- alu_ready in IDLE or MD_HOLD is ignored. The multDiv unit never raises ready in the same cycle an op is issued, so the first cycle of a MUL/DIV op is always IDLE.
- in_valid dropping in MD_WAIT or MD_HOLD is illegal, because stall_up is asserted. The FSM returns to IDLE next cycle and discards md_buf.

## Timing
- Reset (async, rst_n=0): state=IDLE; md_buf=0; all out_* = 0; stall_up=0; md_squash=0.
- Non-MUL/DIV op: result appears on out_* one cycle after it is presented, if mem_stall=0. stall_up stays 0.
- MUL/DIV op: stall_up=1 from the issue cycle through the cycle before load. out_* update on the edge ending the alu_ready cycle, or the edge ending the first mem_stall=0 cycle in MD_HOLD.
- Back-to-back MUL/DIV: the second op is seen in IDLE the cycle after the first leaves, and a new issue begins.
- Reset mid-operation clears the FSM and outputs immediately. The ALU's multDiv shares rst_n and also returns to idle.

## Test plan
- Reset: drive rst_n=0 mid-MD_WAIT → all out_*=0, stall_up=0, state IDLE asynchronously, before the next clk edge.
- ADD stream: in_valid=1, alu_result=0x0000_0005, in_rd=3, in_reg_write=1, mem_stall=0 → next cycle out_valid=1, out_result=5, out_rd=3; stall_up never asserted.
- MUL with model ready after 34 cycles, alu_result=0x0000_0C00 at pulse:
  - stall_up=1 for 34 cycles.
  - out_valid=0 bubbles during the wait.
  - out_result=0xC00 the cycle after the pulse.
  - md_squash stays 0.
- DIV with mem_stall=1 across the ready pulse (alu_result=0x7 at pulse), mem_stall released 3 cycles later:
  - MD_HOLD entered; md_squash=1 for 3 cycles.
  - alu_result changes to garbage during hold, yet out_result=0x7 after release.
- Branch: in_is_branch=1, alu_is_zero=1, in_target=0x100 → out_branch_taken=1, out_target=0x100. With alu_is_zero=0 → out_branch_taken=0.
- mem_stall=1 with a non-MUL/DIV op → out_* frozen, stall_up=1. Release → op loads next edge, stall_up drops.

Source files
------------

// File: rtl/ex_mem_stage.sv
// ex_mem_stage
//   EX/MEM pipeline register with a MUL/DIV stall sequencer. It captures the
//   ALU result, store data, branch target and control bits for the memory
//   stage. While an iterative MUL/DIV runs it holds the front of the pipeline.
//   If the memory stage is stalled when the result arrives, it keeps that
//   result in a local buffer.
//
// Ports
//   clk, rst_n            pipeline clock, asynchronous active-low reset
//   in_valid, in_md_op    live EX instruction / instruction is MUL/DIV class
//   in_is_branch          instruction is a branch or jump
//   alu_result/alu_is_zero ALU result and branch-taken flag
//   alu_ready             one-cycle pulse marking a valid MUL/DIV result
//   in_wdata, in_target   store data and branch/jump target
//   in_rd, in_reg_write, in_mem_read, in_mem_write  destination and controls
//   mem_stall             memory stage cannot accept; hold EX/MEM
//   stall_up              hold IF/ID/EX registers and PC
//   md_squash             mask ALU ctrl so the MUL/DIV unit does not restart
//   out_*                 registered EX/MEM contents
module ex_mem_stage #(
  parameter int XLEN          = 32,
  parameter int REG_ADDR_BITS = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     in_md_op,
  input  logic                     in_is_branch,
  input  logic [XLEN-1:0]          alu_result,
  input  logic                     alu_is_zero,
  input  logic                     alu_ready,
  input  logic [XLEN-1:0]          in_wdata,
  input  logic [XLEN-1:0]          in_target,
  input  logic [REG_ADDR_BITS-1:0] in_rd,
  input  logic                     in_reg_write,
  input  logic                     in_mem_read,
  input  logic                     in_mem_write,
  input  logic                     mem_stall,
  output logic                     stall_up,
  output logic                     md_squash,
  output logic                     out_valid,
  output logic [XLEN-1:0]          out_result,
  output logic [XLEN-1:0]          out_wdata,
  output logic [XLEN-1:0]          out_target,
  output logic [REG_ADDR_BITS-1:0] out_rd,
  output logic                     out_reg_write,
  output logic                     out_mem_read,
  output logic                     out_mem_write,
  output logic                     out_branch_taken
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MD_WAIT = 2'd1;
  localparam logic [1:0] MD_HOLD = 2'd2;

  logic [1:0]      state_r;
  logic [1:0]      state_nxt_s;
  logic [XLEN-1:0] md_buf_r;
  logic [XLEN-1:0] md_buf_nxt_s;
  logic [XLEN-1:0] result_sel_s;
  logic            ex_done_s;
  logic            load_s;

  // An instruction is finished when it is a plain op, or a MUL/DIV whose result
  // is either arriving now or already buffered.
  always_comb begin
    ex_done_s    = in_valid & (~in_md_op |
                               ((state_r == MD_WAIT) & alu_ready) |
                               (state_r == MD_HOLD));
    load_s       = ~mem_stall;
    result_sel_s = (state_r == MD_HOLD) ? md_buf_r : alu_result;
    // Gated by rst_n so that upstream sees no stall while reset is asserted.
    stall_up     = rst_n & in_valid & ~(ex_done_s & load_s);
    md_squash    = (state_r == MD_HOLD);
  end

  // Sequencer next-state and buffer capture.
  always_comb begin
    state_nxt_s  = state_r;
    md_buf_nxt_s = md_buf_r;
    case (state_r)
      IDLE: begin
        if (in_valid & in_md_op) begin
          state_nxt_s = MD_WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MD_WAIT: begin
        if (~in_valid) begin
          // Illegal drop while stalled: abandon the operation.
          state_nxt_s  = IDLE;
          md_buf_nxt_s = {XLEN{1'b0}};
        end else if (alu_ready & mem_stall) begin
          state_nxt_s  = MD_HOLD;
          md_buf_nxt_s = alu_result;
        end else if (alu_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = MD_WAIT;
        end
      end
      MD_HOLD: begin
        if (~in_valid) begin
          state_nxt_s  = IDLE;
          md_buf_nxt_s = {XLEN{1'b0}};
        end else if (~mem_stall) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = MD_HOLD;
        end
      end
      default: begin
        state_nxt_s  = IDLE;
        md_buf_nxt_s = {XLEN{1'b0}};
      end
    endcase
  end

  // Sequencer state and MUL/DIV result buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      md_buf_r <= {XLEN{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      md_buf_r <= md_buf_nxt_s;
    end
  end

  // EX/MEM register. A bubble clears only valid and the side-effecting
  // controls; the data fields keep their previous value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid        <= 1'b0;
      out_result       <= {XLEN{1'b0}};
      out_wdata        <= {XLEN{1'b0}};
      out_target       <= {XLEN{1'b0}};
      out_rd           <= {REG_ADDR_BITS{1'b0}};
      out_reg_write    <= 1'b0;
      out_mem_read     <= 1'b0;
      out_mem_write    <= 1'b0;
      out_branch_taken <= 1'b0;
    end else if (load_s && ex_done_s) begin
      out_valid        <= 1'b1;
      out_result       <= result_sel_s;
      out_wdata        <= in_wdata;
      out_target       <= in_target;
      out_rd           <= in_rd;
      out_reg_write    <= in_reg_write;
      out_mem_read     <= in_mem_read;
      out_mem_write    <= in_mem_write;
      out_branch_taken <= in_is_branch & alu_is_zero;
    end else if (load_s) begin
      out_valid        <= 1'b0;
      out_reg_write    <= 1'b0;
      out_mem_read     <= 1'b0;
      out_mem_write    <= 1'b0;
      out_branch_taken <= 1'b0;
    end else begin
      out_valid        <= out_valid;
    end
  end

endmodule
